// File: rtl/axis_adc_acq_sequencer.sv
// rtl/axis_adc_acq_sequencer.sv - armed/triggered, decimating ADC acquisition sequencer with AXI-Stream output
// Optional channel-A level trigger is compiled in when ADC_ACQ_LEVEL_TRIG_EN is defined.
module axis_adc_acq_sequencer #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNT_WIDTH        = 20,
  parameter int DEC_WIDTH        = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        cfg_arm,
  input  logic                        cfg_abort,
  input  logic [CNT_WIDTH-1:0]        cfg_samples,
  input  logic [DEC_WIDTH-1:0]        cfg_decim,
  input  logic [15:0]                 cfg_level,
  input  logic                        cfg_edge,
  input  logic                        trig_ext,
  input  logic                        s_axis_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tlast,
  output logic [1:0]                  sts_state,
  output logic [CNT_WIDTH-1:0]        sts_count,
  output logic                        sts_overflow
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e                      state_q, state_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]        samples_q, samples_d;
  logic [DEC_WIDTH-1:0]        decim_q, decim_d;
  logic [DEC_WIDTH-1:0]        dec_q, dec_d;
  logic                        ovf_q, ovf_d;
  logic                        tvalid_q, tvalid_d;
  logic                        tlast_q, tlast_d;
  logic [AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [2:0]                  sync_q;

  logic arm_ok;
  logic ext_rise;
  logic level_hit;
  logic keep;
  logic last;

  assign arm_ok   = cfg_arm && !cfg_abort && (cfg_samples != '0) &&
                    (state_q == S_IDLE || state_q == S_DONE);
  assign ext_rise = sync_q[1] && !sync_q[2];
  assign last     = (cnt_q == samples_q - CNT_WIDTH'(1));

`ifdef ADC_ACQ_LEVEL_TRIG_EN
  logic signed [15:0] level_q, level_d;
  logic               edge_q, edge_d;
  logic signed [15:0] prev_q, prev_d;
  logic               prev_vld_q, prev_vld_d;
  logic signed [15:0] cur_a;

  assign cur_a     = s_axis_tdata[15:0];
  assign level_hit = prev_vld_q &&
                     (edge_q ? (prev_q > level_q && cur_a <= level_q)
                             : (prev_q < level_q && cur_a >= level_q));

  // Previous channel-A sample only tracks while waiting for a trigger.
  always_comb begin
    level_d    = level_q;
    edge_d     = edge_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    if (arm_ok) begin
      level_d    = cfg_level;
      edge_d     = cfg_edge;
      prev_d     = '0;
      prev_vld_d = 1'b0;
    end else if (state_q == S_ARMED && s_axis_tvalid) begin
      prev_d     = cur_a;
      prev_vld_d = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      level_q    <= '0;
      edge_q     <= 1'b0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      level_q    <= level_d;
      edge_q     <= edge_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
    end
  end
`else
  logic unused_level_cfg;
  assign unused_level_cfg = ^{cfg_level, cfg_edge};
  assign level_hit        = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    samples_d = samples_q;
    decim_d   = decim_q;
    dec_d     = dec_q;
    ovf_d     = ovf_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    tdata_d   = tdata_q;
    keep      = 1'b0;

    if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end

    if (cfg_abort) begin
      state_d  = S_IDLE;
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm_ok) begin
            state_d   = S_ARMED;
            samples_d = cfg_samples;
            decim_d   = cfg_decim;
            cnt_d     = '0;
            ovf_d     = 1'b0;
            dec_d     = '0;
          end
        end
        S_ARMED: begin
          if (s_axis_tvalid && (ext_rise || level_hit)) begin
            keep    = 1'b1;
            state_d = S_CAPTURE;
            dec_d   = (decim_q == '0) ? '0 : DEC_WIDTH'(1);
          end
        end
        S_CAPTURE: begin
          if (s_axis_tvalid) begin
            keep  = (dec_q == '0);
            dec_d = (dec_q == decim_q) ? '0 : dec_q + DEC_WIDTH'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase

      // A kept sample always counts; it is lost only when the output register is still occupied.
      if (keep) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (!tvalid_q || m_axis_tready) begin
          tvalid_d = 1'b1;
          tdata_d  = s_axis_tdata;
          tlast_d  = last;
        end else begin
          ovf_d = 1'b1;
        end
        if (last) state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      samples_q <= '0;
      decim_q   <= '0;
      dec_q     <= '0;
      ovf_q     <= 1'b0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tdata_q   <= '0;
      sync_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      samples_q <= samples_d;
      decim_q   <= decim_d;
      dec_q     <= dec_d;
      ovf_q     <= ovf_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      tdata_q   <= tdata_d;
      sync_q    <= {sync_q[1:0], trig_ext};
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign sts_state     = state_q;
  assign sts_count     = cnt_q;
  assign sts_overflow  = ovf_q;

endmodule

// File: tb/tb_axis_adc_acq_sequencer.sv
// tb/tb_axis_adc_acq_sequencer.sv - scoreboard bench for axis_adc_acq_sequencer
// Level-trigger scenario is built only when ADC_ACQ_LEVEL_TRIG_EN is defined.
module tb_axis_adc_acq_sequencer;

  logic        aclk;
  logic        aresetn;
  logic        cfg_arm;
  logic        cfg_abort;
  logic [19:0] cfg_samples;
  logic [15:0] cfg_decim;
  logic [15:0] cfg_level;
  logic        cfg_edge;
  logic        trig_ext;
  logic        s_axis_tvalid;
  logic [31:0] s_axis_tdata;
  logic        m_axis_tready;
  logic        m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic [1:0]  sts_state;
  logic [19:0] sts_count;
  logic        sts_overflow;

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];
  logic [32:0] obs_q[$];

  axis_adc_acq_sequencer dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_arm       (cfg_arm),
    .cfg_abort     (cfg_abort),
    .cfg_samples   (cfg_samples),
    .cfg_decim     (cfg_decim),
    .cfg_level     (cfg_level),
    .cfg_edge      (cfg_edge),
    .trig_ext      (trig_ext),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tready (m_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .sts_state     (sts_state),
    .sts_count     (sts_count),
    .sts_overflow  (sts_overflow)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Transfers are captured on the falling edge, ahead of the rising edge that completes them.
  always @(negedge aclk) begin
    if (aresetn && m_axis_tvalid && m_axis_tready)
      obs_q.push_back({m_axis_tlast, m_axis_tdata});
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_arm(input int nsamp, input int decim, input int level, input bit edge_sel);
    cfg_samples = 20'(nsamp);
    cfg_decim   = 16'(decim);
    cfg_level   = 16'(level);
    cfg_edge    = edge_sel;
    cfg_arm     = 1'b1;
    tick();
    cfg_arm     = 1'b0;
  endtask

  // Ramp stream (A = i, B = ~i); ext trigger raised at trig_at, so the first kept sample is trig_at+2.
  task automatic stream(input int n, input int trig_at, input bit gaps, input bit push_exp,
                        input int nsamp, input int decim);
    int phase = 0;
    int kept  = 0;
    bit cap   = 0;
    bit v;
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      v = !(gaps && i > trig_at + 2 && (i % 4) == 3);
      d = {~16'(i), 16'(i)};
      s_axis_tvalid = v;
      s_axis_tdata  = d;
      trig_ext      = (i >= trig_at);
      if (v && kept < nsamp) begin
        if (!cap && i == trig_at + 2) begin
          cap   = 1'b1;
          phase = 0;
        end
        if (cap) begin
          if (phase == 0) begin
            kept++;
            if (push_exp) exp_q.push_back({(kept == nsamp), d});
          end
          phase = (phase == decim) ? 0 : phase + 1;
        end
      end
      tick();
    end
    s_axis_tvalid = 1'b0;
    trig_ext      = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (2) tick();
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, sts_state, sts_count, sts_overflow} !== 56'h0) begin
      errors++;
      $display("FAIL reset_outputs got tv=%b tl=%b td=%h st=%0d cnt=%0d ovf=%b required all zero",
               m_axis_tvalid, m_axis_tlast, m_axis_tdata, sts_state, sts_count, sts_overflow);
    end
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [32:0] e, o;
    exp_q.delete(); obs_q.delete();
    m_axis_tready = 1'b1;
    do_arm(4, 0, 0, 1'b0);
    checks++;
    if (sts_state !== 2'd1) begin errors++; $display("FAIL basic_armed state=%0d required=1", sts_state); end
    stream(12, 2, 1'b0, 1'b1, 4, 0);
    repeat (5) tick();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL basic_words got=%0d required=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL basic_word got=%h required=%h", o, e); end
    end
    checks++;
    if (sts_state !== 2'd3 || sts_count !== 20'd4 || sts_overflow !== 1'b0) begin
      errors++; $display("FAIL basic_status st=%0d cnt=%0d ovf=%b required st=3 cnt=4 ovf=0",
                         sts_state, sts_count, sts_overflow);
    end
  endtask

  task automatic test_decim(input bit gaps);
    logic [32:0] e, o;
    exp_q.delete(); obs_q.delete();
    m_axis_tready = 1'b1;
    do_arm(3, 2, 0, 1'b0);
    stream(20, 2, gaps, 1'b1, 3, 2);
    repeat (5) tick();
    checks++;
    if (obs_q.size() != 3 || exp_q.size() != 3) begin
      errors++; $display("FAIL decim_words gaps=%0d got=%0d required=3", gaps, obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL decim_word gaps=%0d got=%h required=%h", gaps, o, e); end
    end
    checks++;
    if (sts_state !== 2'd3 || sts_count !== 20'd3) begin
      errors++; $display("FAIL decim_status st=%0d cnt=%0d required st=3 cnt=3", sts_state, sts_count);
    end
  endtask

  task automatic test_overflow();
    logic [32:0] e, o;
    exp_q.delete(); obs_q.delete();
    m_axis_tready = 1'b0;
    do_arm(8, 0, 0, 1'b0);
    stream(14, 0, 1'b0, 1'b0, 8, 0);
    exp_q.push_back({1'b0, ~16'd2, 16'd2});
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== {~16'd2, 16'd2} || m_axis_tlast !== 1'b0) begin
      errors++; $display("FAIL ovf_held tv=%b td=%h tl=%b required tv=1 td=fffd0002 tl=0",
                         m_axis_tvalid, m_axis_tdata, m_axis_tlast);
    end
    checks++;
    if (sts_overflow !== 1'b1 || sts_count !== 20'd8 || sts_state !== 2'd3) begin
      errors++; $display("FAIL ovf_status ovf=%b cnt=%0d st=%0d required ovf=1 cnt=8 st=3",
                         sts_overflow, sts_count, sts_state);
    end
    m_axis_tready = 1'b1;
    repeat (4) tick();
    checks++;
    if (obs_q.size() != 1) begin errors++; $display("FAIL ovf_words got=%0d required=1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL ovf_word got=%h required=%h", o, e); end
    end
  endtask

  task automatic test_arm_ignored();
    logic [32:0] e, o;
    exp_q.delete(); obs_q.delete();
    m_axis_tready = 1'b1;
    do_arm(2, 0, 0, 1'b0);
    do_arm(5, 1, 0, 1'b0);
    checks++;
    if (sts_state !== 2'd1) begin errors++; $display("FAIL rearm_state st=%0d required=1", sts_state); end
    stream(10, 1, 1'b0, 1'b1, 2, 0);
    repeat (5) tick();
    checks++;
    if (obs_q.size() != 2) begin errors++; $display("FAIL rearm_words got=%0d required=2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL rearm_word got=%h required=%h", o, e); end
    end
  endtask

`ifdef ADC_ACQ_LEVEL_TRIG_EN
  task automatic test_level_trig();
    int up[5]   = '{90, 95, 100, 105, 110};
    int down[5] = '{110, 105, 100, 95, 90};
    logic [32:0] e, o;
    exp_q.delete(); obs_q.delete();
    m_axis_tready = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      do_arm(1, 0, 100, pass[0]);
      for (int k = 0; k < 5; k++) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {16'h0, 16'((pass == 0) ? up[k] : down[k])};
        if (((pass == 0) ? up[k] : down[k]) == 100) exp_q.push_back({1'b1, 16'h0, 16'd100});
        tick();
      end
      s_axis_tvalid = 1'b0;
      repeat (3) tick();
    end
    checks++;
    if (obs_q.size() != 2) begin errors++; $display("FAIL level_words got=%0d required=2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL level_word got=%h required=%h", o, e); end
    end
  endtask
`endif

  task automatic test_abort();
    m_axis_tready = 1'b0;
    do_arm(8, 0, 0, 1'b0);
    stream(6, 0, 1'b0, 1'b0, 8, 0);
    cfg_abort     = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'h1234_5678;
    tick();
    cfg_abort     = 1'b0;
    s_axis_tvalid = 1'b0;
    checks++;
    if (sts_state !== 2'd0 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
      errors++; $display("FAIL abort_state st=%0d tv=%b tl=%b required st=0 tv=0 tl=0",
                         sts_state, m_axis_tvalid, m_axis_tlast);
    end
    checks++;
    if (sts_count !== 20'd4 || sts_overflow !== 1'b1) begin
      errors++; $display("FAIL abort_hold cnt=%0d ovf=%b required cnt=4 ovf=1", sts_count, sts_overflow);
    end
    cfg_samples = 20'd8;
    cfg_arm     = 1'b1;
    cfg_abort   = 1'b1;
    tick();
    cfg_arm     = 1'b0;
    cfg_abort   = 1'b0;
    checks++;
    if (sts_state !== 2'd0 || sts_count !== 20'd4) begin
      errors++; $display("FAIL arm_abort st=%0d cnt=%0d required st=0 cnt=4", sts_state, sts_count);
    end
    m_axis_tready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_async_reset();
    m_axis_tready = 1'b1;
    do_arm(8, 0, 0, 1'b0);
    stream(5, 0, 1'b0, 1'b0, 8, 0);
    #2;
    aresetn = 1'b0;
    #1;
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, sts_state, sts_count, sts_overflow} !== 56'h0) begin
      errors++; $display("FAIL async_reset tv=%b tl=%b td=%h st=%0d cnt=%0d ovf=%b required all zero",
                         m_axis_tvalid, m_axis_tlast, m_axis_tdata, sts_state, sts_count, sts_overflow);
    end
    tick();
    aresetn = 1'b1;
    tick();
    do_arm(0, 0, 0, 1'b0);
    tick();
    checks++;
    if (sts_state !== 2'd0) begin errors++; $display("FAIL zero_samples_arm st=%0d required=0", sts_state); end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    cfg_arm       = 1'b0;
    cfg_abort     = 1'b0;
    cfg_samples   = '0;
    cfg_decim     = '0;
    cfg_level     = '0;
    cfg_edge      = 1'b0;
    trig_ext      = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b1;
    aresetn       = 1'b0;
    test_reset();
    test_basic();
    test_decim(1'b0);
    test_decim(1'b1);
    test_overflow();
    test_arm_ignored();
`ifdef ADC_ACQ_LEVEL_TRIG_EN
    test_level_trig();
`endif
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
